// File: rtl/alu_reg_imm_iq.sv
// Purpose: unified reg-reg / reg-imm ALU issue queue with per-operand wakeup and ROB-relative kill.
// Latency: issue is combinational from entry state; enqueue to earliest issue is 1 cycle.
// Backpressure: iq_enq_ready drops while every entry is valid; issue waits on issue_ready.
module alu_reg_imm_iq #(
  parameter int IQ_ENTRIES                  = 12,
  parameter int FAST_FORWARD_PIPE_COUNT     = 4,
  parameter int LOG_FAST_FORWARD_PIPE_COUNT = $clog2(FAST_FORWARD_PIPE_COUNT),
  parameter int LOG_PR_COUNT                = 7,
  parameter int LOG_ROB_ENTRIES             = 6,
  parameter int PRF_BANK_COUNT              = 4,
  parameter int LOG_PRF_BANK_COUNT          = $clog2(PRF_BANK_COUNT)
) (
  input  logic                                   CLK,
  input  logic                                   nRST,
  input  logic                                   iq_enq_valid,
  input  logic                                   iq_enq_is_imm,
  input  logic [3:0]                             iq_enq_op,
  input  logic [11:0]                            iq_enq_imm12,
  input  logic [LOG_PR_COUNT-1:0]                iq_enq_A_PR,
  input  logic                                   iq_enq_A_ready,
  input  logic                                   iq_enq_A_is_zero,
  input  logic [LOG_PR_COUNT-1:0]                iq_enq_B_PR,
  input  logic                                   iq_enq_B_ready,
  input  logic                                   iq_enq_B_is_zero,
  input  logic [LOG_PR_COUNT-1:0]                iq_enq_dest_PR,
  input  logic [LOG_ROB_ENTRIES-1:0]             iq_enq_ROB_index,
  output logic                                   iq_enq_ready,
  input  logic [PRF_BANK_COUNT-1:0]              WB_bus_valid_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank,
  input  logic [FAST_FORWARD_PIPE_COUNT-1:0]     fast_forward_valid_by_pipe,
  input  logic [FAST_FORWARD_PIPE_COUNT-1:0][LOG_PR_COUNT-1:0] fast_forward_PR_by_pipe,
  input  logic [LOG_ROB_ENTRIES-1:0]             rob_head_index,
  input  logic                                   kill_valid,
  input  logic                                   kill_yes_self,
  input  logic [LOG_ROB_ENTRIES-1:0]             kill_ROB_index,
  input  logic                                   issue_ready,
  output logic                                   issue_valid,
  output logic                                   issue_is_imm,
  output logic [3:0]                             issue_op,
  output logic [11:0]                            issue_imm12,
  output logic                                   issue_A_is_reg,
  output logic                                   issue_A_is_bus_forward,
  output logic                                   issue_A_is_fast_forward,
  output logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0] issue_A_fast_forward_pipe,
  output logic [LOG_PRF_BANK_COUNT-1:0]          issue_A_bank,
  output logic                                   issue_B_is_reg,
  output logic                                   issue_B_is_bus_forward,
  output logic                                   issue_B_is_fast_forward,
  output logic [LOG_FAST_FORWARD_PIPE_COUNT-1:0] issue_B_fast_forward_pipe,
  output logic [LOG_PRF_BANK_COUNT-1:0]          issue_B_bank,
  output logic [LOG_PR_COUNT-1:0]                issue_dest_PR,
  output logic [LOG_ROB_ENTRIES-1:0]             issue_ROB_index,
  output logic                                   PRF_req_A_valid,
  output logic [LOG_PR_COUNT-1:0]                PRF_req_A_PR,
  output logic                                   PRF_req_B_valid,
  output logic [LOG_PR_COUNT-1:0]                PRF_req_B_PR
);

  localparam int LB = LOG_PRF_BANK_COUNT;
  localparam int LF = LOG_FAST_FORWARD_PIPE_COUNT;

  typedef struct packed {
    logic                       valid;
    logic                       is_imm;
    logic [3:0]                 op;
    logic [11:0]                imm12;
    logic [LOG_PR_COUNT-1:0]    A_PR;
    logic                       A_ready;
    logic                       A_is_zero;
    logic [LOG_PR_COUNT-1:0]    B_PR;
    logic                       B_ready;
    logic                       B_is_zero;
    logic [LOG_PR_COUNT-1:0]    dest_PR;
    logic [LOG_ROB_ENTRIES-1:0] ROB_index;
  } entry_t;

  entry_t q   [IQ_ENTRIES];
  entry_t nxt [IQ_ENTRIES];
  entry_t upd [IQ_ENTRIES+1];
  entry_t new_ent;

  logic [IQ_ENTRIES-1:0] a_bus, a_ff, b_bus, b_ff, a_rdy, b_rdy, killed, cand, issue_oh;
  logic [LF-1:0]         a_pipe [IQ_ENTRIES];
  logic [LF-1:0]         b_pipe [IQ_ENTRIES];
  logic [IQ_ENTRIES:0]   shift;   // shift[j]: issued index is <= j
  logic [IQ_ENTRIES:0]   enq_oh;  // lowest invalid entry, top bit always 0
  logic                  sel_any, free_any, enq_fire;

  // Age compare relative to the ROB head so wrap-around orders correctly.
  function automatic logic is_killed(input logic [LOG_ROB_ENTRIES-1:0] rob,
                                     input logic [LOG_ROB_ENTRIES-1:0] head,
                                     input logic [LOG_ROB_ENTRIES-1:0] kidx,
                                     input logic kv,
                                     input logic kself);
    logic [LOG_ROB_ENTRIES-1:0] r, rk;
    r  = rob - head;
    rk = kidx - head;
    return kv & ((r > rk) | ((r == rk) & kself));
  endfunction

  // Per-entry wakeup from WB bus and fast-forward pipes, kill, and issue eligibility.
  always_comb begin
    for (int j = 0; j < IQ_ENTRIES; j++) begin
      a_bus[j] = WB_bus_valid_by_bank[q[j].A_PR[LB-1:0]] &
                 (WB_bus_upper_PR_by_bank[q[j].A_PR[LB-1:0]] == q[j].A_PR[LOG_PR_COUNT-1:LB]);
      b_bus[j] = WB_bus_valid_by_bank[q[j].B_PR[LB-1:0]] &
                 (WB_bus_upper_PR_by_bank[q[j].B_PR[LB-1:0]] == q[j].B_PR[LOG_PR_COUNT-1:LB]);
      a_ff[j]   = 1'b0;
      b_ff[j]   = 1'b0;
      a_pipe[j] = '0;
      b_pipe[j] = '0;
      // Ascending scan so the highest matching pipe index is the one reported.
      for (int p = 0; p < FAST_FORWARD_PIPE_COUNT; p++) begin
        if (fast_forward_valid_by_pipe[p] && (fast_forward_PR_by_pipe[p] == q[j].A_PR)) begin
          a_ff[j]   = 1'b1;
          a_pipe[j] = LF'(p);
        end
        if (fast_forward_valid_by_pipe[p] && (fast_forward_PR_by_pipe[p] == q[j].B_PR)) begin
          b_ff[j]   = 1'b1;
          b_pipe[j] = LF'(p);
        end
      end
      a_rdy[j]  = q[j].A_ready | a_bus[j] | a_ff[j] | q[j].A_is_zero;
      b_rdy[j]  = q[j].B_ready | b_bus[j] | b_ff[j] | q[j].B_is_zero | q[j].is_imm;
      killed[j] = is_killed(q[j].ROB_index, rob_head_index, kill_ROB_index, kill_valid, kill_yes_self);
      cand[j]   = q[j].valid & a_rdy[j] & b_rdy[j] & ~killed[j] & issue_ready;
    end
  end

  // Oldest-first select (lowest index) plus the prefix mask that drives compaction.
  always_comb begin
    issue_oh = '0;
    shift    = '0;
    sel_any  = 1'b0;
    for (int j = 0; j < IQ_ENTRIES; j++) begin
      issue_oh[j] = cand[j] & ~sel_any;
      sel_any     = sel_any | cand[j];
      shift[j]    = sel_any;
    end
    shift[IQ_ENTRIES] = sel_any;
    issue_valid       = sel_any;
  end

  // Enqueue slot search and acceptance; a full queue refuses even if an issue frees a slot.
  always_comb begin
    enq_oh   = '0;
    free_any = 1'b0;
    for (int j = 0; j < IQ_ENTRIES; j++) begin
      enq_oh[j] = ~q[j].valid & ~free_any;
      free_any  = free_any | ~q[j].valid;
    end
    iq_enq_ready = free_any;
    enq_fire     = iq_enq_valid & free_any &
                   ~is_killed(iq_enq_ROB_index, rob_head_index, kill_ROB_index, kill_valid, kill_yes_self);
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.is_imm    = iq_enq_is_imm;
    new_ent.op        = iq_enq_op;
    new_ent.imm12     = iq_enq_imm12;
    new_ent.A_PR      = iq_enq_A_PR;
    new_ent.A_ready   = iq_enq_A_ready;
    new_ent.A_is_zero = iq_enq_A_is_zero;
    new_ent.B_PR      = iq_enq_B_PR;
    new_ent.B_ready   = iq_enq_B_ready;
    new_ent.B_is_zero = iq_enq_B_is_zero;
    new_ent.dest_PR   = iq_enq_dest_PR;
    new_ent.ROB_index = iq_enq_ROB_index;
  end

  // Next state: capture bus wakeups, drop killed entries, shift down above the issue, then write the enqueue.
  always_comb begin
    for (int j = 0; j < IQ_ENTRIES; j++) begin
      upd[j]         = q[j];
      upd[j].valid   = q[j].valid & ~killed[j];
      upd[j].A_ready = q[j].A_ready | a_bus[j];
      upd[j].B_ready = q[j].B_ready | b_bus[j];
    end
    upd[IQ_ENTRIES] = '0;
    for (int j = 0; j < IQ_ENTRIES; j++) begin
      nxt[j] = shift[j] ? upd[j+1] : upd[j];
      // The free slot moves down by one when the issue sits at or below it.
      if (enq_fire && ((enq_oh[j] && !shift[j]) || (enq_oh[j+1] && shift[j+1]))) begin
        nxt[j] = new_ent;
      end
    end
  end

  // One-hot OR-mux of the selected entry onto the issue and PRF request ports.
  always_comb begin
    issue_is_imm              = 1'b0;
    issue_op                  = '0;
    issue_imm12               = '0;
    issue_dest_PR             = '0;
    issue_ROB_index           = '0;
    issue_A_is_reg            = 1'b0;
    issue_A_is_bus_forward    = 1'b0;
    issue_A_is_fast_forward   = 1'b0;
    issue_A_fast_forward_pipe = '0;
    issue_A_bank              = '0;
    issue_B_is_reg            = 1'b0;
    issue_B_is_bus_forward    = 1'b0;
    issue_B_is_fast_forward   = 1'b0;
    issue_B_fast_forward_pipe = '0;
    issue_B_bank              = '0;
    PRF_req_A_PR              = '0;
    PRF_req_B_PR              = '0;
    for (int j = 0; j < IQ_ENTRIES; j++) begin
      if (issue_oh[j]) begin
        issue_is_imm              |= q[j].is_imm;
        issue_op                  |= q[j].op;
        issue_imm12               |= q[j].imm12;
        issue_dest_PR             |= q[j].dest_PR;
        issue_ROB_index           |= q[j].ROB_index;
        issue_A_is_reg            |= ~(q[j].A_is_zero | a_bus[j] | a_ff[j]);
        issue_A_is_bus_forward    |= a_bus[j];
        issue_A_is_fast_forward   |= a_ff[j];
        issue_A_fast_forward_pipe |= a_pipe[j];
        issue_A_bank              |= q[j].A_PR[LB-1:0];
        issue_B_is_reg            |= ~(q[j].B_is_zero | b_bus[j] | b_ff[j] | q[j].is_imm);
        issue_B_is_bus_forward    |= b_bus[j];
        issue_B_is_fast_forward   |= b_ff[j];
        issue_B_fast_forward_pipe |= b_pipe[j];
        issue_B_bank              |= q[j].B_PR[LB-1:0];
        PRF_req_A_PR              |= q[j].A_PR;
        PRF_req_B_PR              |= q[j].B_PR;
      end
    end
    PRF_req_A_valid = issue_A_is_reg;
    PRF_req_B_valid = issue_B_is_reg;
  end

  // Entry state register; reset clears every entry at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int j = 0; j < IQ_ENTRIES; j++) q[j] <= '0;
    end else begin
      for (int j = 0; j < IQ_ENTRIES; j++) q[j] <= nxt[j];
    end
  end

endmodule

// File: tb/tb_alu_reg_imm_iq.sv
// Bench for alu_reg_imm_iq: directed steps, expected issues queued when stimulus is driven.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
// Failing comparisons are reported with tag, observed and expected values.
module tb_alu_reg_imm_iq;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic                  iq_enq_valid, iq_enq_is_imm;
  logic [3:0]            iq_enq_op;
  logic [11:0]           iq_enq_imm12;
  logic [6:0]            iq_enq_A_PR, iq_enq_B_PR, iq_enq_dest_PR;
  logic                  iq_enq_A_ready, iq_enq_A_is_zero, iq_enq_B_ready, iq_enq_B_is_zero;
  logic [5:0]            iq_enq_ROB_index;
  logic                  iq_enq_ready;
  logic [3:0]            WB_bus_valid_by_bank;
  logic [3:0][4:0]       WB_bus_upper_PR_by_bank;
  logic [3:0]            fast_forward_valid_by_pipe;
  logic [3:0][6:0]       fast_forward_PR_by_pipe;
  logic [5:0]            rob_head_index, kill_ROB_index;
  logic                  kill_valid, kill_yes_self, issue_ready;
  logic                  issue_valid, issue_is_imm;
  logic [3:0]            issue_op;
  logic [11:0]           issue_imm12;
  logic                  issue_A_is_reg, issue_A_is_bus_forward, issue_A_is_fast_forward;
  logic [1:0]            issue_A_fast_forward_pipe, issue_A_bank;
  logic                  issue_B_is_reg, issue_B_is_bus_forward, issue_B_is_fast_forward;
  logic [1:0]            issue_B_fast_forward_pipe, issue_B_bank;
  logic [6:0]            issue_dest_PR;
  logic [5:0]            issue_ROB_index;
  logic                  PRF_req_A_valid, PRF_req_B_valid;
  logic [6:0]            PRF_req_A_PR, PRF_req_B_PR;

  typedef struct packed {
    logic       valid;
    logic       is_imm;
    logic [3:0] op;
    logic [11:0] imm;
    logic [6:0] dest;
    logic [5:0] rob;
    logic       a_reg, a_bus, a_ff;
    logic [1:0] a_pipe, a_bank;
    logic       b_reg, b_bus, b_ff;
    logic [1:0] b_pipe, b_bank;
    logic       pa_v;
    logic [6:0] pa_pr;
    logic       pb_v;
    logic [6:0] pb_pr;
  } iss_t;

  iss_t sb[$];
  int   checks;
  int   errors;

  alu_reg_imm_iq dut (
    .CLK(CLK), .nRST(nRST),
    .iq_enq_valid(iq_enq_valid), .iq_enq_is_imm(iq_enq_is_imm), .iq_enq_op(iq_enq_op),
    .iq_enq_imm12(iq_enq_imm12), .iq_enq_A_PR(iq_enq_A_PR), .iq_enq_A_ready(iq_enq_A_ready),
    .iq_enq_A_is_zero(iq_enq_A_is_zero), .iq_enq_B_PR(iq_enq_B_PR), .iq_enq_B_ready(iq_enq_B_ready),
    .iq_enq_B_is_zero(iq_enq_B_is_zero), .iq_enq_dest_PR(iq_enq_dest_PR),
    .iq_enq_ROB_index(iq_enq_ROB_index), .iq_enq_ready(iq_enq_ready),
    .WB_bus_valid_by_bank(WB_bus_valid_by_bank), .WB_bus_upper_PR_by_bank(WB_bus_upper_PR_by_bank),
    .fast_forward_valid_by_pipe(fast_forward_valid_by_pipe), .fast_forward_PR_by_pipe(fast_forward_PR_by_pipe),
    .rob_head_index(rob_head_index), .kill_valid(kill_valid), .kill_yes_self(kill_yes_self),
    .kill_ROB_index(kill_ROB_index), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_is_imm(issue_is_imm), .issue_op(issue_op), .issue_imm12(issue_imm12),
    .issue_A_is_reg(issue_A_is_reg), .issue_A_is_bus_forward(issue_A_is_bus_forward),
    .issue_A_is_fast_forward(issue_A_is_fast_forward), .issue_A_fast_forward_pipe(issue_A_fast_forward_pipe),
    .issue_A_bank(issue_A_bank), .issue_B_is_reg(issue_B_is_reg), .issue_B_is_bus_forward(issue_B_is_bus_forward),
    .issue_B_is_fast_forward(issue_B_is_fast_forward), .issue_B_fast_forward_pipe(issue_B_fast_forward_pipe),
    .issue_B_bank(issue_B_bank), .issue_dest_PR(issue_dest_PR), .issue_ROB_index(issue_ROB_index),
    .PRF_req_A_valid(PRF_req_A_valid), .PRF_req_A_PR(PRF_req_A_PR),
    .PRF_req_B_valid(PRF_req_B_valid), .PRF_req_B_PR(PRF_req_B_PR)
  );

  always #5 CLK = ~CLK;

  function automatic iss_t obs();
    iss_t o;
    o = '{issue_valid, issue_is_imm, issue_op, issue_imm12, issue_dest_PR, issue_ROB_index,
          issue_A_is_reg, issue_A_is_bus_forward, issue_A_is_fast_forward, issue_A_fast_forward_pipe, issue_A_bank,
          issue_B_is_reg, issue_B_is_bus_forward, issue_B_is_fast_forward, issue_B_fast_forward_pipe, issue_B_bank,
          PRF_req_A_valid, PRF_req_A_PR, PRF_req_B_valid, PRF_req_B_PR};
    return o;
  endfunction

  // Expected issue record; is_reg follows from which forwarding source (if any) supplies the operand.
  function automatic iss_t mk(input int is_imm, input int op, input int imm, input int dest, input int rob,
                              input int a_pr, input int a_zero, input int a_bus, input int a_ff, input int a_pipe,
                              input int b_pr, input int b_bus, input int b_ff, input int b_pipe);
    iss_t e;
    logic [6:0] ap, bp;
    ap = 7'(a_pr);
    bp = 7'(b_pr);
    e = '0;
    e.valid  = 1'b1;
    e.is_imm = 1'(is_imm);
    e.op     = 4'(op);
    e.imm    = 12'(imm);
    e.dest   = 7'(dest);
    e.rob    = 6'(rob);
    e.a_reg  = (a_zero == 0) && (a_bus == 0) && (a_ff == 0);
    e.a_bus  = 1'(a_bus);
    e.a_ff   = 1'(a_ff);
    e.a_pipe = 2'(a_pipe);
    e.a_bank = ap[1:0];
    e.b_reg  = (is_imm == 0) && (b_bus == 0) && (b_ff == 0);
    e.b_bus  = 1'(b_bus);
    e.b_ff   = 1'(b_ff);
    e.b_pipe = 2'(b_pipe);
    e.b_bank = bp[1:0];
    e.pa_v   = e.a_reg;
    e.pa_pr  = ap;
    e.pb_v   = e.b_reg;
    e.pb_pr  = bp;
    return e;
  endfunction

  task automatic idle();
    iq_enq_valid = 0; iq_enq_is_imm = 0; iq_enq_op = '0; iq_enq_imm12 = '0;
    iq_enq_A_PR = '0; iq_enq_B_PR = '0; iq_enq_dest_PR = '0; iq_enq_ROB_index = '0;
    iq_enq_A_ready = 0; iq_enq_A_is_zero = 0; iq_enq_B_ready = 0; iq_enq_B_is_zero = 0;
    WB_bus_valid_by_bank = '0; WB_bus_upper_PR_by_bank = '0;
    fast_forward_valid_by_pipe = '0; fast_forward_PR_by_pipe = '0;
    kill_valid = 0; kill_yes_self = 0; kill_ROB_index = '0; issue_ready = 1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic enq(input int is_imm, input int op, input int imm, input int a_pr, input int b_pr,
                     input int a_rdy, input int b_rdy, input int a_zero, input int dest, input int rob);
    iq_enq_valid = 1; iq_enq_is_imm = 1'(is_imm); iq_enq_op = 4'(op); iq_enq_imm12 = 12'(imm);
    iq_enq_A_PR = 7'(a_pr); iq_enq_B_PR = 7'(b_pr); iq_enq_A_ready = 1'(a_rdy); iq_enq_B_ready = 1'(b_rdy);
    iq_enq_A_is_zero = 1'(a_zero); iq_enq_dest_PR = 7'(dest); iq_enq_ROB_index = 6'(rob);
  endtask

  task automatic wb(input int pr);
    logic [6:0] p;
    p = 7'(pr);
    WB_bus_valid_by_bank[p[1:0]]    = 1'b1;
    WB_bus_upper_PR_by_bank[p[1:0]] = p[6:2];
  endtask

  task automatic ff(input int pipe, input int pr);
    fast_forward_valid_by_pipe[pipe] = 1'b1;
    fast_forward_PR_by_pipe[pipe]    = 7'(pr);
  endtask

  task automatic kill(input int idx, input int self_kill);
    kill_valid = 1; kill_ROB_index = 6'(idx); kill_yes_self = 1'(self_kill);
  endtask

  task automatic expect_issue(input string tag);
    iss_t o, e;
    o = obs();
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s: issue observed %h with nothing expected", tag, o);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    iss_t o;
    o = obs();
    checks++;
    assert (o === '0) else begin
      errors++;
      $error("FAIL %s: observed %h expected all zero", tag, o);
    end
  endtask

  task automatic expect_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rob_head_index = '0;
    idle();
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    settle();
    expect_idle("reset_issue");
    expect_bit("reset_enq_ready", iq_enq_ready, 1'b1);
    nRST = 1'b1;

    // reg-imm op issues the cycle after enqueue
    tick(); enq(1, 3, 12'h7FF, 10, 0, 1, 0, 0, 20, 1); settle();
    expect_idle("t1_enq_cycle");
    sb.push_back(mk(1, 3, 12'h7FF, 20, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); settle(); expect_issue("t1_imm_issue");
    tick(); settle(); expect_idle("t1_drained");

    // WB bus wakeup of B in the issue cycle
    tick(); enq(0, 5, 0, 11, 9, 1, 0, 0, 21, 2); settle(); expect_idle("t2_enq_cycle");
    tick(); wb(9); sb.push_back(mk(0, 5, 0, 21, 2, 11, 0, 0, 0, 0, 9, 1, 0, 0)); settle();
    expect_issue("t2_bus_fwd");
    // bus seen while blocked: stored ready bit lets it issue later from the PRF; A is the zero reg
    tick(); enq(0, 6, 0, 12, 9, 0, 0, 1, 22, 3); settle(); expect_idle("t2b_enq_cycle");
    tick(); wb(9); issue_ready = 0; settle(); expect_idle("t2_blocked");
    tick(); sb.push_back(mk(0, 6, 0, 22, 3, 12, 1, 0, 0, 0, 9, 0, 0, 0)); settle();
    expect_issue("t2_late_reg");

    // fast-forward on pipes 1 and 3 reports pipe 3
    tick(); enq(1, 7, 12'h123, 5, 0, 0, 0, 0, 23, 4); settle(); expect_idle("t3_enq_cycle");
    tick(); ff(0, 6); ff(1, 5); ff(3, 5); fast_forward_PR_by_pipe[2] = 7'd5;
    sb.push_back(mk(1, 7, 12'h123, 23, 4, 5, 0, 0, 1, 3, 0, 0, 0, 0)); settle();
    expect_issue("t3_ff_pipe3");
    tick(); enq(1, 8, 12'h456, 5, 0, 0, 0, 0, 24, 5); settle(); expect_idle("t3b_enq_cycle");
    tick(); ff(1, 5); issue_ready = 0; settle(); expect_idle("t3_ff_blocked");
    tick(); settle(); expect_idle("t3_ff_not_stored");
    tick(); wb(5); sb.push_back(mk(1, 8, 12'h456, 24, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0)); settle();
    expect_issue("t3_bus_drain");

    // fill all entries, none ready
    for (int k = 0; k < 12; k++) begin
      tick(); enq(0, 1, 0, 16 + k, 40 + k, 0, 1, 0, 50 + k, 10 + k); settle();
      expect_bit("t4_fill_ready", iq_enq_ready, 1'b1);
      expect_idle("t4_fill_idle");
    end
    tick(); settle();
    expect_bit("t4_full", iq_enq_ready, 1'b0);
    expect_idle("t4_full_idle");
    // wake entry 4 while an enqueue is attempted into the full queue
    tick(); wb(20); enq(0, 2, 0, 1, 2, 1, 1, 0, 60, 30);
    sb.push_back(mk(0, 1, 0, 54, 14, 20, 0, 1, 0, 0, 44, 0, 0, 0)); settle();
    expect_issue("t4_wake_e4");
    expect_bit("t4_full_during_issue", iq_enq_ready, 1'b0);
    tick(); enq(0, 9, 0, 2, 3, 1, 1, 0, 62, 40); settle();
    expect_bit("t4_ready_after", iq_enq_ready, 1'b1);
    expect_idle("t4_enq_new");
    // old top entry (now index 10) is older than the new entry at index 11
    tick(); wb(27); sb.push_back(mk(0, 1, 0, 61, 21, 27, 0, 1, 0, 0, 51, 0, 0, 0)); settle();
    expect_issue("t4_shifted_top");
    tick(); sb.push_back(mk(0, 9, 0, 62, 40, 2, 0, 0, 0, 0, 3, 0, 0, 0)); settle();
    expect_issue("t4_new_entry");
    tick(); kill(9, 0); wb(16); settle(); expect_idle("t4_kill_no_issue");
    tick(); wb(16); wb(17); wb(18); wb(19); settle(); expect_idle("t4_flushed");

    // ROB wrap-around kill with head at 60
    rob_head_index = 6'd60;
    for (int k = 0; k < 4; k++) begin
      tick(); enq(0, 4'hA, 0, 30 + k, 1, 0, 1, 0, 10 + k, (62 + k) % 64); settle();
    end
    tick(); kill(63, 0); enq(0, 4'hB, 0, 3, 4, 1, 1, 0, 14, 2); settle();
    expect_idle("t5_kill_cycle");
    expect_bit("t5_enq_ready", iq_enq_ready, 1'b1);
    tick(); settle(); expect_idle("t5_dropped_enq");
    tick(); wb(30); wb(31); wb(32); wb(33);
    sb.push_back(mk(0, 4'hA, 0, 10, 62, 30, 0, 1, 0, 0, 1, 0, 0, 0)); settle();
    expect_issue("t5_keep_62");
    tick(); wb(31); wb(32); wb(33);
    sb.push_back(mk(0, 4'hA, 0, 11, 63, 31, 0, 1, 0, 0, 1, 0, 0, 0)); settle();
    expect_issue("t5_keep_63");
    tick(); wb(32); wb(33); settle(); expect_idle("t5_killed_gone");
    // equal ROB index: kept without kill_yes_self, removed with it
    tick(); enq(0, 4'hC, 0, 34, 1, 0, 1, 0, 15, 5); settle();
    tick(); enq(0, 4'hD, 0, 35, 1, 0, 1, 0, 16, 6); settle();
    tick(); kill(6, 0); wb(35);
    sb.push_back(mk(0, 4'hD, 0, 16, 6, 35, 0, 1, 0, 0, 1, 0, 0, 0)); settle();
    expect_issue("t5_equal_no_self");
    tick(); kill(5, 1); wb(34); settle(); expect_idle("t5_equal_self");
    tick(); wb(34); settle(); expect_idle("t5_self_gone");

    // reset pulse with six valid entries
    rob_head_index = '0;
    for (int k = 0; k < 6; k++) begin
      tick(); enq(0, 4'hE, 0, 40 + k, 1, 0, 1, 0, 20 + k, k); settle();
    end
    tick(); wb(40); sb.push_back(mk(0, 4'hE, 0, 20, 0, 40, 0, 1, 0, 0, 1, 0, 0, 0)); settle();
    expect_issue("t6_pre_reset");
    #1 nRST = 1'b0;
    #1;
    expect_idle("t6_reset_issue");
    expect_bit("t6_reset_enq_ready", iq_enq_ready, 1'b1);
    tick(); nRST = 1'b1; wb(41); wb(42); settle(); expect_idle("t6_cleared");
    tick(); enq(0, 4'hF, 0, 7, 8, 1, 1, 0, 30, 9); settle();
    tick(); sb.push_back(mk(0, 4'hF, 0, 30, 9, 7, 0, 0, 0, 0, 8, 0, 0, 0)); settle();
    expect_issue("t6_after_reset");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_empty: %0d expected issues left, 0 required", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_reg_imm_iq.md
# alu_reg_imm_iq

Unified ALU issue queue holding both reg-reg and reg-imm integer ops, with two source operands per entry, per-operand wakeup from the writeback bus and fast-forward pipes, and ROB-relative kill of younger entries on a flush. Sits between dispatch and the ALU pipeline. It issues the oldest ready op each cycle and drives PRF read requests for both operands. Compaction is shift-down-on-issue, so age order is entry index order.

## Interface
- IQ_ENTRIES, 12, queue depth (>=2)
- FAST_FORWARD_PIPE_COUNT, 4, fast-forward notifier pipes
- LOG_FAST_FORWARD_PIPE_COUNT, $clog2(FAST_FORWARD_PIPE_COUNT), pipe index width
- CLK  in  1  clock, one clock domain
- nRST  in  1  reset, asynchronous, active-low
- iq_enq_valid / iq_enq_is_imm  in  1 / 1  enqueue request / B operand is imm12
- iq_enq_op / iq_enq_imm12  in  4 / 12  ALU op / immediate
- iq_enq_A_PR, iq_enq_B_PR  in  LOG_PR_COUNT each  source PRs
- iq_enq_A_ready, iq_enq_B_ready, iq_enq_A_is_zero, iq_enq_B_is_zero  in  1 each  operand status
- iq_enq_dest_PR / iq_enq_ROB_index  in  LOG_PR_COUNT / LOG_ROB_ENTRIES  dest, age tag
- iq_enq_ready  out  1  any entry currently invalid
- WB_bus_valid_by_bank / WB_bus_upper_PR_by_bank  in  PRF_BANK_COUNT / PRF_BANK_COUNT x (LOG_PR_COUNT-LOG_PRF_BANK_COUNT)  writeback wakeup
- fast_forward_valid_by_pipe / fast_forward_PR_by_pipe  in  FAST_FORWARD_PIPE_COUNT / x LOG_PR_COUNT
- rob_head_index  in  LOG_ROB_ENTRIES  oldest ROB entry
- kill_valid / kill_yes_self / kill_ROB_index  in  1 / 1 / LOG_ROB_ENTRIES  flush request
- issue_ready  in  1  pipeline accepts an op this cycle
- issue_valid, issue_is_imm, issue_op, issue_imm12, issue_dest_PR, issue_ROB_index  out  1,1,4,12,LOG_PR_COUNT,LOG_ROB_ENTRIES
- issue_{A,B}_is_reg, _is_bus_forward, _is_fast_forward  out  1 each
- issue_{A,B}_fast_forward_pipe  out  LOG_FAST_FORWARD_PIPE_COUNT;  issue_{A,B}_bank  out  LOG_PRF_BANK_COUNT
- PRF_req_{A,B}_valid / PRF_req_{A,B}_PR  out  1 / LOG_PR_COUNT

## Operation
- Entry: valid, is_imm, op, imm12, A/B PR, ready, is_zero, dest_PR, ROB_index.
- Per-operand (X = A or B), per cycle:
  - bus_fwd = WB_bus_valid_by_bank[PR bank bits] & upper bits match.
  - fast_fwd = any valid pipe with equal PR; pipe field = highest matching pipe index.
  - Operand ready = ready | bus_fwd | fast_fwd | is_zero; B is additionally always ready when is_imm.
- Killed: kill_valid & (rel(ROB_index) > rel(kill_ROB_index) | (equal & kill_yes_self)), where rel(x) = (x - rob_head_index) mod 2^LOG_ROB_ENTRIES.
- Issue candidates: valid & A ready & B ready & ~killed & issue_ready. The lowest index wins.
- Issue outputs for operand X:
  - X_is_reg = ~(is_zero | bus_fwd | fast_fwd), forced 0 for B when is_imm.
  - PRF_req_X_valid = X_is_reg. PRF_req_X_PR = PR. bank = low LOG_PRF_BANK_COUNT bits.
- Fields are one-hot OR-muxed; all are zero when issue_valid=0.
- Next state:
  - Entries at or above the issued index i take entry+1. The top entry becomes invalid.
  - Other entries hold.
  - Stored ready bits become ready | bus_fwd. Fast-forward never sets the stored bit.
  - Killed entries become invalid, wherever they land.
- Enqueue target is the lowest invalid entry e in the current state. Write lands at e-1 if an issue occurs at an index <= e, otherwise at e.
  - Written only if iq_enq_valid & iq_enq_ready & ~killed(iq_enq_ROB_index).
  - Stored operand ready bits are iq_enq_X_ready (no same-cycle wakeup capture).
- Holes left by kill are not compacted except via issue shifting.

## Timing
- Reset (async, nRST low): all entry state 0. Outputs: issue_valid=0, all issue/PRF fields 0, iq_enq_ready=1.
- Issue is combinational from state; enqueue to earliest issue is 1 cycle.
- Full (all valid): iq_enq_ready=0 even if an issue occurs this cycle.
- Simultaneous issue + enqueue + kill is resolved as above in one cycle.
- A killed entry is never issued in its kill cycle.
- rel() wrap-around must hold when ROB indices straddle 0.
- nRST assertion mid-operation clears all entries immediately.

## Test plan
- Reset, then enqueue reg-imm op (A_ready=1, op=4'h3, imm=12'h7FF) -> next cycle issue_valid=1, issue_is_imm=1, PRF_req_A_valid=1, PRF_req_B_valid=0, imm12=12'h7FF.
- Reg-reg op with B_PR=PR 9 not ready; WB bus presents PR 9 on its bank -> issue same cycle with issue_B_is_bus_forward=1; if issue_ready=0, the op issues later with B_is_reg=1.
- Fast-forward PR 5 on pipes 1 and 3 -> issue_A_is_fast_forward=1, pipe=3; next cycle without FF the op is not ready.
- Fill all 12 entries, all not ready -> iq_enq_ready=0. Wake entry 4 -> it issues, entries 5..11 shift to 4..10, and iq_enq_ready becomes 1 the next cycle.
- rob_head=60 (6-bit), entries ROB 62,63,0,1. Kill index 63, kill_yes_self=0 -> entries 0 and 1 are invalidated, 62 and 63 are kept. Same-cycle enqueue of ROB 2 is dropped.
- nRST pulsed with 6 valid entries -> issue_valid=0 and iq_enq_ready=1 immediately.
